// File: rtl/instr_mem_responder_if.sv
// Fetch-side instruction bus between a fetch stage (master) and an instruction memory (slave).
// Handshake: an address transfers on every cycle with req && gnt. gnt is combinational from req, and a
// request stays up until granted. Each transfer returns exactly one rvalid cycle, in order. rvalid has no
// backpressure. rdata and err are meaningful only while rvalid is high.
interface instr_mem_responder_if;
   logic        req;
   logic        gnt;
   logic [31:0] addr;
   logic [31:0] rdata;
   logic        err;
   logic        rvalid;

   modport master (
      output req,
      output addr,
      input  gnt,
      input  rdata,
      input  err,
      input  rvalid
   );

   modport slave (
      input  req,
      input  addr,
      output gnt,
      output rdata,
      output err,
      output rvalid
   );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: grants fetch requests and returns RAM words in order, LATENCY cycles after grant.
// Define IMEM_GNT_THROTTLE_EN to inject LFSR-driven wait states on gnt.
module instr_mem_responder #(
   parameter int unsigned MEM_WORDS       = 1024,
   parameter logic [31:0] BASE_ADDR       = 32'h0,
   parameter int unsigned LATENCY         = 1,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   instr_mem_responder_if.slave                 bus,
   input  logic                                 bd_we_i,
   input  logic [31:0]                          bd_addr_i,
   input  logic [31:0]                          bd_wdata_i,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);
   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   logic [31:0]   mem [MEM_WORDS];
   logic [CW-1:0] count;
   logic          throttle_ok;
   logic          accept;
   logic          rsp_valid;
   logic [32:0]   rel;
   logic          below_base;
   logic [31:0]   idx;
   logic          addr_err;
   logic          unused_rel_bits;

   logic          pipe_valid [LATENCY];
   logic          pipe_err   [LATENCY];
   logic [31:0]   pipe_data  [LATENCY];

`ifdef IMEM_GNT_THROTTLE_EN
   logic [7:0] lfsr;

   // Fibonacci LFSR, taps 8,6,5,4; two low bits at zero model a wait state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= 8'hA5;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end

   assign throttle_ok = (lfsr[1:0] != 2'b00);
`else
   assign throttle_ok = 1'b1;
`endif

   assign bus.gnt = !rst && bus.req && (count < CW'(MAX_OUTSTANDING)) && throttle_ok;
   assign accept  = bus.req && bus.gnt;

   // 33-bit subtract: the borrow flags addresses below the window without wrap-around.
   assign rel             = {1'b0, bus.addr} - {1'b0, BASE_ADDR};
   assign below_base      = rel[32];
   assign idx             = {2'b00, rel[31:2]};
   assign addr_err        = (bus.addr[1:0] != 2'b00) || below_base || (idx >= MEM_WORDS);
   assign unused_rel_bits = ^rel[1:0];

   // Backdoor preload; the nonblocking write lets a same-cycle read see the old word.
   always_ff @(posedge clk) begin
      if (bd_we_i && (bd_addr_i < MEM_WORDS)) begin
         mem[bd_addr_i[AW-1:0]] <= bd_wdata_i;
      end
   end

   for (genvar s = 0; s < LATENCY; s++) begin : g_stage
      if (s == 0) begin : g_read
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               pipe_valid[0] <= 1'b0;
               pipe_err[0]   <= 1'b0;
               pipe_data[0]  <= 32'h0;
            end else begin
               pipe_valid[0] <= accept;
               if (accept) begin
                  pipe_err[0]  <= addr_err;
                  pipe_data[0] <= addr_err ? 32'h0 : mem[idx[AW-1:0]];
               end
            end
         end
      end else begin : g_shift
         // Payload only moves with a valid token so the output stage holds its last response.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               pipe_valid[s] <= 1'b0;
               pipe_err[s]   <= 1'b0;
               pipe_data[s]  <= 32'h0;
            end else begin
               pipe_valid[s] <= pipe_valid[s-1];
               if (pipe_valid[s-1]) begin
                  pipe_err[s]  <= pipe_err[s-1];
                  pipe_data[s] <= pipe_data[s-1];
               end
            end
         end
      end
   end

   assign rsp_valid  = pipe_valid[LATENCY-1];
   assign bus.rvalid = rsp_valid;
   assign bus.rdata  = pipe_data[LATENCY-1];
   assign bus.err    = pipe_err[LATENCY-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (accept && !rsp_valid) begin
         count <= count + CW'(1);
      end else if (!accept && rsp_valid) begin
         count <= count - CW'(1);
      end
   end

   assign outstanding = count;
endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: three parameter sets share one stimulus stream, each checked every cycle
// against a queue-of-pending-responses model, plus a vector table and directed corner-case sequences.
module tb_instr_mem_responder;
   typedef struct packed {
      int          due;
      logic [31:0] data;
      logic        err;
   } rsp_t;

   typedef struct {
      logic [31:0] addr;
      logic        err;
      logic [31:0] data;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [31:0] addr;
   logic        bd_we;
   logic [31:0] bd_addr;
   logic [31:0] bd_wdata;
   int          checks = 0;
   int          errors = 0;

   initial forever #5 clk = ~clk;

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "time limit");
   end

   function automatic logic [31:0] pat(input int i);
      logic [15:0] lo;
      lo = i[15:0];
      case (i)
         0:       return 32'h00000013;
         1:       return 32'h00100093;
         2:       return 32'h00200113;
         3:       return 32'h00300193;
         default: return {lo, ~lo};
      endcase
   endfunction

   task automatic check(input string name, input int ln, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s lane%0d @%0t: got %h expected %h", name, ln, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         tick();
         req   = 1'b0;
         bd_we = 1'b0;
      end
   endtask

   // lane0: LATENCY 1 / MAX 2; lane1: LATENCY 2 / MAX 3; lane2: LATENCY 3 / MAX 1, 64 words at 0x100.
   for (genvar g = 0; g < 3; g++) begin : lane
      localparam int unsigned L  = (g == 0) ? 1 : (g == 1) ? 2 : 3;
      localparam int unsigned MX = (g == 0) ? 2 : (g == 1) ? 3 : 1;
      localparam int unsigned MW = (g == 2) ? 64 : 1024;
      localparam logic [31:0] BA = (g == 2) ? 32'h100 : 32'h0;
      localparam int unsigned CW = $clog2(MX + 1);

      instr_mem_responder_if bus ();
      logic [CW-1:0] cnt;
      logic          gnt_w;
      logic          rvalid_w;
      logic          err_w;
      logic [31:0]   rdata_w;

      assign bus.req  = req;
      assign bus.addr = addr;
      assign gnt_w    = bus.gnt;
      assign rvalid_w = bus.rvalid;
      assign err_w    = bus.err;
      assign rdata_w  = bus.rdata;

      instr_mem_responder #(
         .MEM_WORDS      (MW),
         .BASE_ADDR      (BA),
         .LATENCY        (L),
         .MAX_OUTSTANDING(MX)
      ) dut (
         .clk        (clk),
         .rst        (rst),
         .bus        (bus),
         .bd_we_i    (bd_we),
         .bd_addr_i  (bd_addr),
         .bd_wdata_i (bd_wdata),
         .outstanding(cnt)
      );

      rsp_t        pend [$];
      logic [31:0] shadow [1024];
      logic [31:0] last_data;
      logic        last_err;
      int          cyc = 0;
      logic [7:0]  mlfsr;

      function automatic rsp_t lookup(input logic [31:0] a, input int due);
         longint ua, ub, widx;
         rsp_t   r;
         ua     = {32'h0, a};
         ub     = {32'h0, BA};
         widx   = (ua - ub) / 4;
         r.due  = due;
         r.err  = (ua % 4 != 0) || (ua < ub) || (widx >= longint'(MW));
         r.data = r.err ? 32'h0 : shadow[int'(widx)];
         return r;
      endfunction

      // Sampled mid-cycle: check this cycle's outputs, then apply what the next rising edge commits.
      always @(negedge clk) begin : model
         logic exp_rv;
         logic exp_gnt;
         cyc++;
         if (rst) begin
            pend.delete();
            last_data = 32'h0;
            last_err  = 1'b0;
            mlfsr     = 8'hA5;
            check("rst_gnt", g, 32'(gnt_w), 32'h0);
            check("rst_rvalid", g, 32'(rvalid_w), 32'h0);
            check("rst_rdata", g, rdata_w, 32'h0);
            check("rst_err", g, 32'(err_w), 32'h0);
            check("rst_count", g, 32'(cnt), 32'h0);
         end else begin
            exp_rv = (pend.size() > 0) && (pend[0].due == cyc);
            if (exp_rv) begin
               last_data = pend[0].data;
               last_err  = pend[0].err;
            end
            check("rvalid", g, 32'(rvalid_w), 32'(exp_rv));
            check("rdata", g, rdata_w, last_data);
            check("err", g, 32'(err_w), 32'(last_err));
            check("count", g, 32'(cnt), pend.size());
            exp_gnt = req && (pend.size() < int'(MX));
`ifdef IMEM_GNT_THROTTLE_EN
            exp_gnt = exp_gnt && (mlfsr[1:0] != 2'b00);
            mlfsr   = {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
`endif
            check("gnt", g, 32'(gnt_w), 32'(exp_gnt));
            if (exp_rv) void'(pend.pop_front());
            if (exp_gnt) pend.push_back(lookup(addr, cyc + int'(L)));
         end
         if (bd_we && (bd_addr < MW)) shadow[bd_addr[9:0]] = bd_wdata;
      end
   end

   initial begin : main
      vec_t vec [12];
      logic got;
      int   gcnt;
      int   maxc;
      int   r;

      vec[0]  = '{32'h0000_0000, 1'b0, pat(0)};
      vec[1]  = '{32'h0000_0004, 1'b0, pat(1)};
      vec[2]  = '{32'h0000_0008, 1'b0, pat(2)};
      vec[3]  = '{32'h0000_000C, 1'b0, pat(3)};
      vec[4]  = '{32'h0000_0002, 1'b1, 32'h0};
      vec[5]  = '{32'h0000_1000, 1'b1, 32'h0};
      vec[6]  = '{32'h0000_0FFC, 1'b0, pat(1023)};
      vec[7]  = '{32'hFFFF_FFFC, 1'b1, 32'h0};
      vec[8]  = '{32'h0000_0010, 1'b0, pat(4)};
      vec[9]  = '{32'h0000_0001, 1'b1, 32'h0};
      vec[10] = '{32'h0000_0FFF, 1'b1, 32'h0};
      vec[11] = '{32'h0000_03FC, 1'b0, pat(255)};

      // Request held high during reset: gnt must stay low.
      rst = 1'b1; req = 1'b1; addr = 32'h0;
      bd_we = 1'b0; bd_addr = 32'h0; bd_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      req = 1'b0;

      for (int i = 0; i < 1024; i++) begin
         tick();
         bd_we = 1'b1; bd_addr = i; bd_wdata = pat(i);
      end
      idle(6);

      // Single read at LATENCY 1: gnt in the request cycle, response in the next.
      tick();
      req = 1'b1; addr = 32'h0;
      @(negedge clk);
      check("t1_gnt", 0, 32'(lane[0].gnt_w), 32'h1);
      check("t1_no_early_rvalid", 0, 32'(lane[0].rvalid_w), 32'h0);
      tick();
      req = 1'b0;
      @(negedge clk);
      check("t1_rvalid", 0, 32'(lane[0].rvalid_w), 32'h1);
      check("t1_rdata", 0, lane[0].rdata_w, 32'h00000013);
      check("t1_err", 0, 32'(lane[0].err_w), 32'h0);
      idle(6);

      for (int i = 0; i < 12; i++) begin
         tick();
         req = 1'b1; addr = vec[i].addr;
         @(negedge clk);
         check("vec_gnt", 0, 32'(lane[0].gnt_w), 32'h1);
         tick();
         req = 1'b0;
         got = 1'b0;
         for (int w = 0; w < 8 && !got; w++) begin
            @(negedge clk);
            if (lane[0].rvalid_w) begin
               got = 1'b1;
               check("vec_rdata", 0, lane[0].rdata_w, vec[i].data);
               check("vec_err", 0, 32'(lane[0].err_w), 32'(vec[i].err));
            end
         end
         check("vec_rvalid_seen", 0, 32'(got), 32'h1);
         idle(6);
      end

      // Full-rate burst at LATENCY 2 / MAX 3: four grants, responses in cycles 2..5.
      for (int k = 0; k < 8; k++) begin
         tick();
         req  = (k < 4);
         addr = 4 * k;
         @(negedge clk);
         if (k < 4) check("b2b_gnt", 1, 32'(lane[1].gnt_w), 32'h1);
         check("b2b_rvalid", 1, 32'(lane[1].rvalid_w), 32'((k >= 2) && (k <= 5)));
         if ((k >= 2) && (k <= 5)) check("b2b_rdata", 1, lane[1].rdata_w, pat(k - 2));
      end
      idle(6);

      // MAX 1 / LATENCY 3 with req held: a new grant only once the previous response has retired.
      gcnt = 0;
      maxc = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         req = 1'b1; addr = 32'h100;
         @(negedge clk);
         if (lane[2].gnt_w) gcnt++;
         if (int'(lane[2].cnt) > maxc) maxc = int'(lane[2].cnt);
      end
      idle(6);
      check("mo1_gnt_count", 2, gcnt, 3);
      check("mo1_max_count", 2, maxc, 1);

      // Backdoor write and read of the same word in one cycle returns the old word.
      tick();
      req = 1'b1; addr = 32'd20;
      bd_we = 1'b1; bd_addr = 32'd5; bd_wdata = 32'hDEADBEEF;
      @(negedge clk);
      check("rbw_gnt", 0, 32'(lane[0].gnt_w), 32'h1);
      tick();
      req = 1'b0; bd_we = 1'b0;
      @(negedge clk);
      check("rbw_rvalid", 0, 32'(lane[0].rvalid_w), 32'h1);
      check("rbw_old", 0, lane[0].rdata_w, pat(5));
      tick();
      req = 1'b1; addr = 32'd20;
      tick();
      req = 1'b0;
      @(negedge clk);
      check("rbw_rvalid2", 0, 32'(lane[0].rvalid_w), 32'h1);
      check("rbw_new", 0, lane[0].rdata_w, 32'hDEADBEEF);
      idle(6);

      // Reset with two responses in flight at LATENCY 2: none may appear afterwards.
      tick();
      req = 1'b1; addr = 32'h0;
      tick();
      addr = 32'h4;
      tick();
      req = 1'b0; rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("rst_drop_rvalid", 1, 32'(lane[1].rvalid_w), 32'h0);
         tick();
         if (k == 1) rst = 1'b0;
      end
      req = 1'b1; addr = 32'h0;
      tick();
      req = 1'b0;
      @(negedge clk);
      check("post_rst_early", 1, 32'(lane[1].rvalid_w), 32'h0);
      tick();
      @(negedge clk);
      check("post_rst_rvalid", 1, 32'(lane[1].rvalid_w), 32'h1);
      check("post_rst_rdata", 1, lane[1].rdata_w, 32'h00000013);
      check("post_rst_err", 1, 32'(lane[1].err_w), 32'h0);
      idle(6);

      // Random traffic; the per-lane models do the checking.
      for (int n = 0; n < 1500; n++) begin
         tick();
         req = ($urandom_range(0, 9) < 7);
         r   = $urandom_range(0, 15);
         if (r < 9)       addr = $urandom_range(0, 100) * 4;
         else if (r < 12) addr = 32'h100 + $urandom_range(0, 70) * 4;
         else if (r < 13) addr = $urandom_range(4088, 4100);
         else if (r < 14) addr = 32'hFFFF_FFFC + $urandom_range(0, 3);
         else             addr = $urandom;
         rst      = ($urandom_range(0, 199) == 0);
         bd_we    = !rst && ($urandom_range(0, 7) == 0);
         bd_addr  = $urandom_range(0, 1100);
         bd_wdata = $urandom;
      end
      rst = 1'b0;
      idle(8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
